// File: rtl/gcd_controller.sv
// Control path for the 16-bit repeated-subtraction GCD datapath.
// Moore FSM with a saturating subtract-step counter that bounds every run.
module gcd_controller #(
    parameter int MAX_ITER = 65535,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             gt,
    input  logic             lt,
    input  logic             eq,
    output logic             LdA,
    output logic             LdB,
    output logic             sel1,
    output logic             sel2,
    output logic             sel_in,
    output logic             opa_req,
    output logic             opb_req,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter_cnt
);

    // state  | meaning
    // IDLE   | waiting for start, all outputs low
    // LOAD_A | A <= data_in, operand A requested
    // LOAD_B | B <= data_in, operand B requested
    // CMP    | decide on datapath flags and the iteration cap
    // SUB_A  | A <= A - B
    // SUB_B  | B <= B - A
    // DONE   | result frozen in A (== B)
    // ERR    | iteration cap hit or no compare flag set
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_CMP, S_SUB_A, S_SUB_B, S_DONE, S_ERR
    } state_t;

    localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_ITER);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_iter_cnt;
    logic             w_at_cap;

    assign w_at_cap = (r_iter_cnt == LP_MAX);
    assign iter_cnt = r_iter_cnt;

    // Counter clears on entry to LOAD_A so it already reads 0 while loading.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_iter_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == S_LOAD_A)
                r_iter_cnt <= '0;
            else if ((r_state == S_SUB_A || r_state == S_SUB_B) && !w_at_cap)
                r_iter_cnt <= r_iter_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_LOAD_A;
            S_LOAD_A: w_state_nxt = S_LOAD_B;
            S_LOAD_B: w_state_nxt = S_CMP;
            S_CMP: begin
                if (eq)            w_state_nxt = S_DONE;
                else if (w_at_cap) w_state_nxt = S_ERR;
                else if (gt)       w_state_nxt = S_SUB_A;
                else if (lt)       w_state_nxt = S_SUB_B;
                else               w_state_nxt = S_ERR;
            end
            S_SUB_A:  w_state_nxt = S_CMP;
            S_SUB_B:  w_state_nxt = S_CMP;
            S_DONE:   if (start) w_state_nxt = S_LOAD_A;
            S_ERR:    if (start) w_state_nxt = S_LOAD_A;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        LdA     = 1'b0;
        LdB     = 1'b0;
        sel1    = 1'b0;
        sel2    = 1'b0;
        sel_in  = 1'b0;
        opa_req = 1'b0;
        opb_req = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        case (r_state)
            S_LOAD_A: begin
                LdA = 1'b1; sel_in = 1'b1; opa_req = 1'b1; busy = 1'b1;
            end
            S_LOAD_B: begin
                LdB = 1'b1; sel_in = 1'b1; opb_req = 1'b1; busy = 1'b1;
            end
            S_CMP:    busy = 1'b1;
            S_SUB_A: begin
                LdA = 1'b1; sel2 = 1'b1; busy = 1'b1;
            end
            S_SUB_B: begin
                LdB = 1'b1; sel1 = 1'b1; busy = 1'b1;
            end
            S_DONE:   done = 1'b1;
            S_ERR: begin
                done = 1'b1; err = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: two instances (default cap and MAX_ITER=8), each
// driving a behavioural model of the 16-bit subtract datapath.
module tb_gcd_controller;

    // {LdA,LdB,sel1,sel2,sel_in,opa_req,opb_req,busy,done,err}
    localparam logic [9:0] P_IDLE = 10'b0000000000;
    localparam logic [9:0] P_LDA  = 10'b1000110100;
    localparam logic [9:0] P_LDB  = 10'b0100101100;
    localparam logic [9:0] P_CMP  = 10'b0000000100;
    localparam logic [9:0] P_SUBB = 10'b0110000100;
    localparam logic [9:0] P_SUBA = 10'b1001000100;
    localparam logic [9:0] P_DONE = 10'b0000000010;
    localparam logic [9:0] P_ERR  = 10'b0000000011;

    logic        clk, rst;
    logic        start[2], gt[2], lt[2], eq[2];
    logic        LdA[2], LdB[2], sel1[2], sel2[2], sel_in[2];
    logic        opa_req[2], opb_req[2], busy[2], done[2], err[2];
    logic [15:0] iter_cnt[2];
    logic [15:0] A[2], B[2], opa[2], opb[2], din[2], diff[2];

    int n_chk = 0, n_pass = 0;
    int n_sa, n_sb;
    bit bad_ovl, bad_sel;

    gcd_controller #(.MAX_ITER(65535), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .gt(gt[0]), .lt(lt[0]), .eq(eq[0]),
        .LdA(LdA[0]), .LdB(LdB[0]), .sel1(sel1[0]), .sel2(sel2[0]), .sel_in(sel_in[0]),
        .opa_req(opa_req[0]), .opb_req(opb_req[0]), .busy(busy[0]), .done(done[0]),
        .err(err[0]), .iter_cnt(iter_cnt[0]));

    gcd_controller #(.MAX_ITER(8), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .gt(gt[1]), .lt(lt[1]), .eq(eq[1]),
        .LdA(LdA[1]), .LdB(LdB[1]), .sel1(sel1[1]), .sel2(sel2[1]), .sel_in(sel_in[1]),
        .opa_req(opa_req[1]), .opb_req(opb_req[1]), .busy(busy[1]), .done(done[1]),
        .err(err[1]), .iter_cnt(iter_cnt[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int u = 0; u < 2; u++) begin
            din[u]  = opa_req[u] ? opa[u] : opb[u];
            diff[u] = (sel1[u] ? B[u] : A[u]) - (sel2[u] ? B[u] : A[u]);
            gt[u]   = A[u] > B[u];
            lt[u]   = A[u] < B[u];
            eq[u]   = A[u] == B[u];
        end
    end

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (LdA[u]) A[u] <= sel_in[u] ? din[u] : diff[u];
            if (LdB[u]) B[u] <= sel_in[u] ? din[u] : diff[u];
        end
    end

    function automatic logic [9:0] outs(input int u);
        return {LdA[u], LdB[u], sel1[u], sel2[u], sel_in[u],
                opa_req[u], opb_req[u], busy[u], done[u], err[u]};
    endfunction

    function automatic int ref_gcd(input int a, input int b);
        int x = a, y = b, t;
        while (y != 0) begin
            t = x % y; x = y; y = t;
        end
        return x;
    endfunction

    // Starts a run and returns the cycle count until done (bounded).
    task automatic run_gcd(input int u, input logic [15:0] a, input logic [15:0] b,
                           input bit hold, output int cyc);
        @(negedge clk);
        opa[u] = a; opb[u] = b; start[u] = 1'b1;
        cyc = 0; n_sa = 0; n_sb = 0; bad_ovl = 0; bad_sel = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!hold) start[u] = 1'b0;
            if (LdA[u] && LdB[u]) bad_ovl = 1;
            if (sel_in[u] && !(opa_req[u] || opb_req[u])) bad_sel = 1;
            if (LdA[u] && !sel_in[u]) n_sa++;
            if (LdB[u] && !sel_in[u]) n_sb++;
        end while (!done[u] && cyc < 5000);
    endtask

    task automatic test_reset;
        int k;
        n_chk++; if (outs(0) !== P_IDLE || outs(1) !== P_IDLE) $display("FAIL reset_outs: got %b/%b expected %b", outs(0), outs(1), P_IDLE); else n_pass++;
        n_chk++; if (iter_cnt[0] !== 16'd0) $display("FAIL reset_cnt: got %0d expected 0", iter_cnt[0]); else n_pass++;
        @(negedge clk); rst = 1'b0;
        opa[0] = 16'd100; opb[0] = 16'd3; start[0] = 1'b1;
        k = 0;
        // wait for the second SUB_A so the counter is non-zero when reset hits
        do begin
            @(negedge clk); start[0] = 1'b0; k++;
        end while (!(outs(0) === P_SUBA && iter_cnt[0] === 16'd1) && k < 20);
        n_chk++; if (k >= 20) $display("FAIL reset_reach_sub_a: got timeout expected SUB_A"); else n_pass++;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_chk++; if (outs(0) !== P_IDLE) $display("FAIL reset_mid_run_outs: got %b expected %b", outs(0), P_IDLE); else n_pass++;
            n_chk++; if (iter_cnt[0] !== 16'd0) $display("FAIL reset_mid_run_cnt: got %0d expected 0", iter_cnt[0]); else n_pass++;
        end
        rst = 1'b0;
    endtask

    task automatic test_gcd_12_18;
        logic [9:0] seq [1:8];
        seq = '{P_LDA, P_LDB, P_CMP, P_SUBB, P_CMP, P_SUBA, P_CMP, P_DONE};
        @(negedge clk);
        opa[0] = 16'd12; opb[0] = 16'd18; start[0] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start[0] = 1'b0;
            n_chk++; if (outs(0) !== seq[c]) $display("FAIL gcd12_18_c%0d: got %b expected %b", c, outs(0), seq[c]); else n_pass++;
        end
        n_chk++; if (iter_cnt[0] !== 16'd2) $display("FAIL gcd12_18_cnt: got %0d expected 2", iter_cnt[0]); else n_pass++;
        n_chk++; if (A[0] !== 16'd6 || B[0] !== 16'd6) $display("FAIL gcd12_18_result: got A=%0d B=%0d expected 6/6", A[0], B[0]); else n_pass++;
        @(negedge clk);
        n_chk++; if (outs(0) !== P_DONE || A[0] !== 16'd6) $display("FAIL gcd12_18_hold: got %b A=%0d expected %b A=6", outs(0), A[0], P_DONE); else n_pass++;
    endtask

    task automatic test_long_and_equal;
        int cyc;
        run_gcd(0, 16'd1000, 16'd1, 1'b0, cyc);
        n_chk++; if (cyc !== 2002) $display("FAIL long_latency: got %0d expected 2002", cyc); else n_pass++;
        n_chk++; if (outs(0) !== P_DONE) $display("FAIL long_outs: got %b expected %b", outs(0), P_DONE); else n_pass++;
        n_chk++; if (iter_cnt[0] !== 16'd999 || A[0] !== 16'd1) $display("FAIL long_result: got cnt=%0d A=%0d expected 999/1", iter_cnt[0], A[0]); else n_pass++;
        run_gcd(0, 16'd9, 16'd9, 1'b0, cyc);
        n_chk++; if (cyc !== 4) $display("FAIL equal_latency: got %0d expected 4", cyc); else n_pass++;
        n_chk++; if (iter_cnt[0] !== 16'd0 || A[0] !== 16'd9 || err[0] !== 1'b0) $display("FAIL equal_result: got cnt=%0d A=%0d err=%b expected 0/9/0", iter_cnt[0], A[0], err[0]); else n_pass++;
    endtask

    task automatic test_iter_cap;
        int cyc;
        run_gcd(1, 16'd5, 16'd0, 1'b0, cyc);
        n_chk++; if (cyc !== 20) $display("FAIL zero_latency: got %0d expected 20", cyc); else n_pass++;
        n_chk++; if (n_sa !== 8 || n_sb !== 0) $display("FAIL zero_steps: got sa=%0d sb=%0d expected 8/0", n_sa, n_sb); else n_pass++;
        n_chk++; if (outs(1) !== P_ERR || iter_cnt[1] !== 16'd8) $display("FAIL zero_err: got %b cnt=%0d expected %b cnt=8", outs(1), iter_cnt[1], P_ERR); else n_pass++;
        @(negedge clk);
        n_chk++; if (outs(1) !== P_ERR || iter_cnt[1] !== 16'd8) $display("FAIL zero_err_hold: got %b cnt=%0d expected %b cnt=8", outs(1), iter_cnt[1], P_ERR); else n_pass++;
        run_gcd(1, 16'd0, 16'd0, 1'b0, cyc);
        n_chk++; if (cyc !== 4 || outs(1) !== P_DONE || iter_cnt[1] !== 16'd0) $display("FAIL zero_zero: got cyc=%0d %b cnt=%0d expected 4 %b 0", cyc, outs(1), iter_cnt[1], P_DONE); else n_pass++;
        // eq has priority over the cap: eight steps exactly still succeeds
        run_gcd(1, 16'd9, 16'd1, 1'b0, cyc);
        n_chk++; if (cyc !== 20 || outs(1) !== P_DONE || iter_cnt[1] !== 16'd8 || A[1] !== 16'd1) $display("FAIL cap_exact: got cyc=%0d %b cnt=%0d A=%0d expected 20 %b 8 1", cyc, outs(1), iter_cnt[1], A[1], P_DONE); else n_pass++;
        run_gcd(1, 16'd10, 16'd1, 1'b0, cyc);
        n_chk++; if (cyc !== 20 || outs(1) !== P_ERR || iter_cnt[1] !== 16'd8 || A[1] !== 16'd2) $display("FAIL cap_over: got cyc=%0d %b cnt=%0d A=%0d expected 20 %b 8 2", cyc, outs(1), iter_cnt[1], A[1], P_ERR); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int cyc, k;
        run_gcd(0, 16'd21, 16'd14, 1'b1, cyc);
        n_chk++; if (cyc !== 8 || A[0] !== 16'd7 || iter_cnt[0] !== 16'd2) $display("FAIL held_start_run: got cyc=%0d A=%0d cnt=%0d expected 8/7/2", cyc, A[0], iter_cnt[0]); else n_pass++;
        @(negedge clk);
        start[0] = 1'b0;
        n_chk++; if (outs(0) !== P_LDA || iter_cnt[0] !== 16'd0) $display("FAIL restart_from_done: got %b cnt=%0d expected %b cnt=0", outs(0), iter_cnt[0], P_LDA); else n_pass++;
        k = 0;
        do begin
            @(negedge clk); k++;
        end while (!done[0] && k < 50);
        n_chk++; if (k !== 7 || A[0] !== 16'd7 || iter_cnt[0] !== 16'd2) $display("FAIL restart_result: got cyc=%0d A=%0d cnt=%0d expected 7/7/2", k, A[0], iter_cnt[0]); else n_pass++;
    endtask

    task automatic test_random_sweep;
        int cyc, a, b, g;
        for (int i = 0; i < 16; i++) begin
            a = $urandom_range(1, 1000);
            b = $urandom_range(1, 1000);
            g = ref_gcd(a, b);
            run_gcd(0, 16'(a), 16'(b), 1'b0, cyc);
            n_chk++; if (done[0] !== 1'b1 || err[0] !== 1'b0 || A[0] !== 16'(g)) $display("FAIL sweep_gcd(%0d,%0d): got done=%b err=%b A=%0d expected 1/0/%0d", a, b, done[0], err[0], A[0], g); else n_pass++;
            n_chk++; if (bad_ovl || bad_sel) $display("FAIL sweep_ctrl(%0d,%0d): got overlap=%b selin=%b expected 0/0", a, b, bad_ovl, bad_sel); else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0; opa[u] = '0; opb[u] = '0;
        end
        repeat (2) @(negedge clk);
        test_reset;
        test_gcd_12_18;
        test_long_and_equal;
        test_iter_cap;
        test_back_to_back;
        test_random_sweep;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
